// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Counter widths never collapse to zero bits, even for tiny ranges.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter; strobes o_bit_end on the last tick of each bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_bit_end
);

  localparam int CW = clog2_min1(OVERSAMPLE);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt;

  assign o_bit_end = i_tick && !i_clear && (cnt == LAST_CNT);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      cnt <= '0;
    end else if (i_tick) begin
      cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter: DATA_BITS payload LSB first, optional even/odd parity, 1 or 2 stop bits.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | line high, o_tx_ready=1, waiting for i_tx_start
// ST_START  | driving the start bit (0)
// ST_DATA   | shifting payload bits out, LSB first
// ST_PARITY | driving the latched parity bit
// ST_STOP   | driving one or two stop bits (1)
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic [1:0]           i_parity_mode,
  input  logic                 i_two_stop,
  output logic                 o_tx_ready,
  output logic                 o_tx_done,
  output logic                 o_tx
);

  localparam int BW = clog2_min1(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 par_bit;
  logic                 par_en;
  logic                 two_stop;
  logic                 tx_r;
  logic                 done_r;
  logic                 bit_end;

  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (state == ST_IDLE),
    .i_tick    (i_tick),
    .o_bit_end (bit_end)
  );

  assign o_tx_ready = (state == ST_IDLE);
  assign o_tx_done  = done_r;
  assign o_tx       = tx_r;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      par_en   <= 1'b0;
      two_stop <= 1'b0;
      tx_r     <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_r <= 1'b1;
          if (i_tx_start) begin
            state    <= ST_START;
            tx_r     <= 1'b0;
            shreg    <= i_data;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            two_stop <= i_two_stop;
            par_en   <= (i_parity_mode == PAR_EVEN) || (i_parity_mode == PAR_ODD);
            par_bit  <= (i_parity_mode == PAR_ODD) ? ~^i_data : ^i_data;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state <= ST_DATA;
            tx_r  <= shreg[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en ? ST_PARITY : ST_STOP;
              tx_r    <= par_en ? par_bit : 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_r    <= shreg[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state <= ST_STOP;
            tx_r  <= 1'b1;
          end
        end
        ST_STOP: begin
          tx_r <= 1'b1;
          if (bit_end) begin
            if (stop_cnt == two_stop) begin
              state    <= ST_IDLE;
              stop_cnt <= 1'b0;
              done_r   <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8-bit and 7-bit instances, tick every 4 clocks.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start8, start7;
  logic [7:0] data8;
  logic [6:0] data7;
  logic [1:0] pm8, pm7;
  logic       ts8, ts7;
  logic       tx8, rdy8, done8;
  logic       tx7, rdy7, done7;
  logic       sel7 = 1'b0;

  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;
  int done_cnt8 = 0;

  logic [11:0] bits;
  int          dr;
  int          snap;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start8), .i_data(data8),
    .i_parity_mode(pm8), .i_two_stop(ts8), .o_tx_ready(rdy8), .o_tx_done(done8), .o_tx(tx8)
  );

  uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(16)) dut7 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start7), .i_data(data7),
    .i_parity_mode(pm7), .i_two_stop(ts7), .o_tx_ready(rdy7), .o_tx_done(done7), .o_tx(tx7)
  );

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  always @(posedge clk) if (tick) ticks_seen <= ticks_seen + 1;
  always @(negedge clk) if (done8) done_cnt8 <= done_cnt8 + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [7:0] d, input logic [1:0] pm, input logic ts, input logic hold);
    check_val("ready_before_start", sel7 ? rdy7 : rdy8, 1);
    if (sel7) begin
      start7 = 1'b1; data7 = d[6:0]; pm7 = pm; ts7 = ts;
    end else begin
      start8 = 1'b1; data8 = d; pm8 = pm; ts8 = ts;
    end
    @(negedge clk);
    if (!hold) begin
      start7 = 1'b0;
      start8 = 1'b0;
    end
    check_val("start_bit", sel7 ? tx7 : tx8, 0);
  endtask

  // Samples mid-bit on tick offsets 8+16k; returns in the o_tx_done cycle.
  task automatic capture(input int nbits, input int perturb_rel,
                         output logic [11:0] cap, output int done_rel);
    int base, rel, k;
    bit perturbed;
    base = ticks_seen;
    cap = '0;
    k = 0;
    done_rel = -1;
    perturbed = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rel = ticks_seen - base;
      if (k < nbits && rel == 8 + 16 * k) begin
        cap[k] = sel7 ? tx7 : tx8;
        k++;
      end
      if (perturb_rel >= 0) begin
        if (!perturbed && rel == perturb_rel) begin
          start8 = 1'b1; data8 = 8'hFF; pm8 = 2'b01; perturbed = 1;
        end else if (perturbed) begin
          start8 = 1'b0;
        end
      end
      if (sel7 ? done7 : done8) begin
        done_rel = rel;
        return;
      end
      @(negedge clk);
    end
    check_val("capture_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    start8 = 0; start7 = 0; data8 = '0; data7 = '0;
    pm8 = 2'b00; pm7 = 2'b00; ts8 = 0; ts7 = 0;
    repeat (3) @(negedge clk);
    check_val("rst_tx8", tx8, 1);
    check_val("rst_rdy8", rdy8, 1);
    check_val("rst_done8", done8, 0);
    check_val("rst_tx7", tx7, 1);
    check_val("rst_rdy7", rdy7, 1);
    check_val("rst_done7", done7, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1, A5
    launch(8'hA5, 2'b00, 1'b0, 1'b0);
    capture(10, -1, bits, dr);
    check_val("t1_bits", bits, {1'b1, 8'hA5, 1'b0});
    check_val("t1_ticks", dr, 160);
    check_val("t1_ready_in_done", rdy8, 1);
    @(negedge clk);
    check_val("t1_done_width", done8, 0);

    // 7-bit data, even then odd parity
    sel7 = 1'b1;
    launch(8'h35, 2'b01, 1'b0, 1'b0);
    capture(10, -1, bits, dr);
    check_val("t2_even_bits", bits, {1'b1, 1'b0, 7'h35, 1'b0});
    check_val("t2_even_ticks", dr, 160);
    launch(8'h35, 2'b10, 1'b0, 1'b0);
    capture(10, -1, bits, dr);
    check_val("t2_odd_bits", bits, {1'b1, 1'b1, 7'h35, 1'b0});
    check_val("t2_odd_ticks", dr, 160);
    launch(8'h35, 2'b11, 1'b0, 1'b0);
    capture(9, -1, bits, dr);
    check_val("t2_rsvd_bits", bits, {1'b1, 7'h35, 1'b0});
    check_val("t2_rsvd_ticks", dr, 144);
    sel7 = 1'b0;
    @(negedge clk);

    // two stop bits
    launch(8'h00, 2'b00, 1'b1, 1'b0);
    capture(11, -1, bits, dr);
    check_val("t3_bits", bits, {2'b11, 8'h00, 1'b0});
    check_val("t3_ticks", dr, 176);
    ts8 = 1'b0;
    @(negedge clk);

    // back-to-back with start held high
    launch(8'h01, 2'b00, 1'b0, 1'b1);
    data8 = 8'h80;
    capture(10, -1, bits, dr);
    check_val("t4_f1_bits", bits, {1'b1, 8'h01, 1'b0});
    check_val("t4_f1_ticks", dr, 160);
    check_val("t4_stop_line", tx8, 1);
    @(negedge clk);
    start8 = 1'b0;
    check_val("t4_no_gap_tx", tx8, 0);
    check_val("t4_no_gap_rdy", rdy8, 0);
    capture(10, -1, bits, dr);
    check_val("t4_f2_bits", bits, {1'b1, 8'h80, 1'b0});
    check_val("t4_f2_ticks", dr, 160);
    @(negedge clk);

    // reset in the middle of data bit 4
    launch(8'h00, 2'b00, 1'b0, 1'b0);
    snap = done_cnt8;
    repeat (350) @(negedge clk);
    check_val("t5_pre_tx", tx8, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("t5_rst_tx", tx8, 1);
    check_val("t5_rst_rdy", rdy8, 1);
    check_val("t5_rst_done", done8, 0);
    repeat (200) @(negedge clk);
    check_val("t5_no_done", done_cnt8, snap);
    launch(8'h3C, 2'b00, 1'b0, 1'b0);
    capture(10, -1, bits, dr);
    check_val("t5_bits", bits, {1'b1, 8'h3C, 1'b0});
    check_val("t5_ticks", dr, 160);
    @(negedge clk);

    // busy start and parity change mid-frame are ignored
    launch(8'hA5, 2'b00, 1'b0, 1'b0);
    capture(10, 40, bits, dr);
    pm8 = 2'b00;
    check_val("t6_bits", bits, {1'b1, 8'hA5, 1'b0});
    check_val("t6_ticks", dr, 160);
    @(negedge clk);
    check_val("t6_idle_after", rdy8, 1);
    check_val("t6_line_idle", tx8, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
